// File: rtl/memcmd_decoder.sv
// DDR4-style command/address decoder: registers one-cycle command strobes,
// tracks the CKE power mode and MPR read mode, and forwards bank/address.
module memcmd_decoder #(
  parameter int unsigned MPR_MR  = 3,
  parameter int unsigned MPR_BIT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cke,
  input  logic        cs_n,
  input  logic        act_n,
  input  logic        ras_n,
  input  logic        cas_n,
  input  logic        we_n,
  input  logic [3:0]  bg_ba,
  input  logic [13:0] addr,
  output logic        ACT,
  output logic        RD,
  output logic        RDA,
  output logic        WR,
  output logic        WRA,
  output logic        PR,
  output logic        PRA,
  output logic        REF,
  output logic        SRF,
  output logic        PD,
  output logic        PDX,
  output logic        DPD,
  output logic        DPDX,
  output logic        MRW,
  output logic        MRR,
  output logic        CFG,
  output logic        BST,
  output logic        CKEH,
  output logic        CKEL,
  output logic [3:0]  cmd_bank,
  output logic [16:0] cmd_addr,
  output logic [1:0]  pwr_mode
);

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    PDN    = 2'd1,
    SREF   = 2'd2,
    DPDN   = 2'd3
  } pwr_t;

  localparam int unsigned S_ACT  = 0;
  localparam int unsigned S_RD   = 1;
  localparam int unsigned S_RDA  = 2;
  localparam int unsigned S_WR   = 3;
  localparam int unsigned S_WRA  = 4;
  localparam int unsigned S_PR   = 5;
  localparam int unsigned S_PRA  = 6;
  localparam int unsigned S_REF  = 7;
  localparam int unsigned S_SRF  = 8;
  localparam int unsigned S_PD   = 9;
  localparam int unsigned S_PDX  = 10;
  localparam int unsigned S_DPD  = 11;
  localparam int unsigned S_DPDX = 12;
  localparam int unsigned S_MRW  = 13;
  localparam int unsigned S_MRR  = 14;
  localparam int unsigned S_CFG  = 15;
  localparam int unsigned S_BST  = 16;

  pwr_t        state, state_nx;
  logic        cke_q;
  logic        mpr_mode, mpr_nx;
  logic [16:0] stb_q, stb_nx;
  logic        ckeh_q, ckel_q;
  logic [3:0]  bank_nx;
  logic [16:0] addr_nx;
  logic [2:0]  code;
  logic        cke_fall, cke_rise;

  assign code     = {ras_n, cas_n, we_n};
  assign cke_fall = cke_q & ~cke;
  assign cke_rise = ~cke_q & cke;

  always_comb begin
    state_nx = state;
    mpr_nx   = mpr_mode;
    stb_nx   = '0;
    bank_nx  = cmd_bank;
    addr_nx  = cmd_addr;
    unique case (state)
      NORMAL: begin
        if (cke_q && cke && !cs_n) begin
          if (!act_n) begin
            stb_nx[S_ACT] = 1'b1;
            bank_nx       = bg_ba;
            addr_nx       = {code, addr};
          end else if (code != 3'b111) begin
            bank_nx = bg_ba;
            addr_nx = {7'b0, addr[9:0]};
            unique case (code)
              3'b000: begin
                stb_nx[S_MRW] = 1'b1;
                addr_nx       = {3'b0, addr};
                if (bg_ba[1:0] == MPR_MR[1:0]) mpr_nx = addr[MPR_BIT];
              end
              3'b001:  stb_nx[S_REF] = 1'b1;
              3'b010:  stb_nx[addr[10] ? S_PRA : S_PR] = 1'b1;
              3'b011:  stb_nx[S_BST] = 1'b1;
              3'b100:  stb_nx[addr[10] ? S_WRA : S_WR] = 1'b1;
              3'b101: begin
                if (mpr_mode) stb_nx[S_MRR] = 1'b1;
                else          stb_nx[addr[10] ? S_RDA : S_RD] = 1'b1;
              end
              default: stb_nx[S_CFG] = 1'b1;
            endcase
          end
        end else if (cke_fall) begin
          // Power-down entry strobes leave cmd_bank/cmd_addr holding
          if (cs_n || (act_n && code == 3'b111)) begin
            stb_nx[S_PD] = 1'b1;
            state_nx     = PDN;
          end else if (act_n && code == 3'b001) begin
            stb_nx[S_SRF] = 1'b1;
            state_nx      = SREF;
          end else if (act_n && code == 3'b011) begin
            stb_nx[S_DPD] = 1'b1;
            state_nx      = DPDN;
          end
        end
      end
      default: begin
        if (cke_rise) begin
          state_nx = NORMAL;
          if (state == PDN) stb_nx[S_PDX] = 1'b1;
          if (state == DPDN) begin
            stb_nx[S_DPDX] = 1'b1;
            mpr_nx         = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= NORMAL;
      cke_q    <= 1'b1;
      mpr_mode <= 1'b0;
      stb_q    <= '0;
      ckeh_q   <= 1'b0;
      ckel_q   <= 1'b0;
      cmd_bank <= '0;
      cmd_addr <= '0;
    end else begin
      state    <= state_nx;
      cke_q    <= cke;
      mpr_mode <= mpr_nx;
      stb_q    <= stb_nx;
      ckeh_q   <= cke_rise;
      ckel_q   <= cke_fall;
      cmd_bank <= bank_nx;
      cmd_addr <= addr_nx;
    end
  end

  assign ACT      = stb_q[S_ACT];
  assign RD       = stb_q[S_RD];
  assign RDA      = stb_q[S_RDA];
  assign WR       = stb_q[S_WR];
  assign WRA      = stb_q[S_WRA];
  assign PR       = stb_q[S_PR];
  assign PRA      = stb_q[S_PRA];
  assign REF      = stb_q[S_REF];
  assign SRF      = stb_q[S_SRF];
  assign PD       = stb_q[S_PD];
  assign PDX      = stb_q[S_PDX];
  assign DPD      = stb_q[S_DPD];
  assign DPDX     = stb_q[S_DPDX];
  assign MRW      = stb_q[S_MRW];
  assign MRR      = stb_q[S_MRR];
  assign CFG      = stb_q[S_CFG];
  assign BST      = stb_q[S_BST];
  assign CKEH     = ckeh_q;
  assign CKEL     = ckel_q;
  assign pwr_mode = state;

endmodule

// File: tb/tb_memcmd_decoder.sv
// Scoreboard bench for memcmd_decoder: directed scenarios then random pins,
// expected responses from a command-level reference model.
module tb_memcmd_decoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cke = 1'b1, cs_n = 1'b1, act_n = 1'b1, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
  logic [3:0]  bg_ba = '0;
  logic [13:0] addr = '0;
  logic ACT, RD, RDA, WR, WRA, PR, PRA, REF, SRF, PD, PDX, DPD, DPDX;
  logic MRW, MRR, CFG, BST, CKEH, CKEL;
  logic [3:0]  cmd_bank;
  logic [16:0] cmd_addr;
  logic [1:0]  pwr_mode;

  memcmd_decoder #(.MPR_MR(3), .MPR_BIT(2)) dut (
    .clk(clk), .rst_n(rst_n), .cke(cke), .cs_n(cs_n), .act_n(act_n),
    .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n), .bg_ba(bg_ba), .addr(addr),
    .ACT(ACT), .RD(RD), .RDA(RDA), .WR(WR), .WRA(WRA), .PR(PR), .PRA(PRA),
    .REF(REF), .SRF(SRF), .PD(PD), .PDX(PDX), .DPD(DPD), .DPDX(DPDX),
    .MRW(MRW), .MRR(MRR), .CFG(CFG), .BST(BST), .CKEH(CKEH), .CKEL(CKEL),
    .cmd_bank(cmd_bank), .cmd_addr(cmd_addr), .pwr_mode(pwr_mode)
  );

  always #5 clk = ~clk;

  localparam int C_NONE = -1, C_MULTI = -2;
  localparam int C_ACT = 0, C_RD = 1, C_RDA = 2, C_WR = 3, C_WRA = 4, C_PR = 5,
                 C_PRA = 6, C_REF = 7, C_SRF = 8, C_PD = 9, C_PDX = 10, C_DPD = 11,
                 C_DPDX = 12, C_MRW = 13, C_MRR = 14, C_CFG = 15, C_BST = 16;

  typedef struct {
    int          cmd;
    logic        ckeh, ckel;
    logic [3:0]  bank;
    logic [16:0] addr;
    logic [1:0]  pwr;
  } exp_t;

  exp_t sb[$];
  int checks = 0, failures = 0;

  // reference model state: power mode 0..3, previous cke, MPR flag, forwarded fields
  int          m_mode;
  logic        m_ckeq, m_mpr;
  logic [3:0]  m_bank;
  logic [16:0] m_addr;

  task automatic model_reset();
    m_mode = 0; m_ckeq = 1'b1; m_mpr = 1'b0; m_bank = '0; m_addr = '0;
  endtask

  task automatic model(input logic k, input logic cs, input logic an, input logic r,
                       input logic c, input logic w, input logic [3:0] bb,
                       input logic [13:0] a);
    exp_t e;
    int code;
    code   = 4 * int'(r) + 2 * int'(c) + int'(w);
    e.cmd  = C_NONE;
    e.ckel = m_ckeq && !k;
    e.ckeh = !m_ckeq && k;
    if (m_mode == 0) begin
      if (m_ckeq && k && !cs) begin
        if (!an) begin
          e.cmd = C_ACT; m_bank = bb; m_addr = {r, c, w, a};
        end else begin
          case (code)
            0: e.cmd = C_MRW;
            1: e.cmd = C_REF;
            2: e.cmd = a[10] ? C_PRA : C_PR;
            3: e.cmd = C_BST;
            4: e.cmd = a[10] ? C_WRA : C_WR;
            5: e.cmd = m_mpr ? C_MRR : (a[10] ? C_RDA : C_RD);
            6: e.cmd = C_CFG;
            default: e.cmd = C_NONE;
          endcase
          if (e.cmd != C_NONE) begin
            m_bank = bb;
            m_addr = (e.cmd == C_MRW) ? {3'b0, a} : {7'b0, a[9:0]};
          end
          if (e.cmd == C_MRW && bb[1:0] == 2'd3) m_mpr = a[2];
        end
      end else if (m_ckeq && !k) begin
        if (cs || (an && code == 7))  begin e.cmd = C_PD;  m_mode = 1; end
        else if (an && code == 1)     begin e.cmd = C_SRF; m_mode = 2; end
        else if (an && code == 3)     begin e.cmd = C_DPD; m_mode = 3; end
      end
    end else if (!m_ckeq && k) begin
      if (m_mode == 1) e.cmd = C_PDX;
      if (m_mode == 3) begin e.cmd = C_DPDX; m_mpr = 1'b0; end
      m_mode = 0;
    end
    m_ckeq = k;
    e.bank = m_bank;
    e.addr = m_addr;
    e.pwr  = 2'(m_mode);
    sb.push_back(e);
  endtask

  task automatic drive(input logic k, input logic cs, input logic an, input logic [2:0] rcw,
                       input logic [3:0] bb, input logic [13:0] a);
    @(negedge clk);
    cke = k; cs_n = cs; act_n = an; {ras_n, cas_n, we_n} = rcw; bg_ba = bb; addr = a;
    model(k, cs, an, rcw[2], rcw[1], rcw[0], bb, a);
  endtask

  task automatic nop(input logic k);
    drive(k, 1'b1, 1'b1, 3'b111, 4'h0, 14'h0);
  endtask

  function automatic int dut_cmd();
    logic [16:0] v;
    int n, idx;
    v = {BST, CFG, MRR, MRW, DPDX, DPD, PDX, PD, SRF, REF, PRA, PR, WRA, WR, RDA, RD, ACT};
    n = 0; idx = C_NONE;
    for (int i = 0; i < 17; i++) if (v[i]) begin n++; idx = i; end
    return (n > 1) ? C_MULTI : idx;
  endfunction

  // monitor: one registered response per cycle, compared against the queue head
  always @(posedge clk) begin
    #1;
    if (rst_n && sb.size() > 0) begin
      exp_t e;
      int   got;
      e   = sb.pop_front();
      got = dut_cmd();
      checks++;
      if (got != e.cmd || CKEH !== e.ckeh || CKEL !== e.ckel || cmd_bank !== e.bank ||
          cmd_addr !== e.addr || pwr_mode !== e.pwr) begin
        failures++;
        $display("FAIL outputs t=%0t: cmd=%0d ckeh=%b ckel=%b bank=%h addr=%h pwr=%0d, required cmd=%0d ckeh=%b ckel=%b bank=%h addr=%h pwr=%0d",
                 $time, got, CKEH, CKEL, cmd_bank, cmd_addr, pwr_mode,
                 e.cmd, e.ckeh, e.ckel, e.bank, e.addr, e.pwr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic k;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (dut_cmd() != C_NONE || CKEH || CKEL || cmd_bank != 4'h0 || cmd_addr != 17'h0 || pwr_mode != 2'd0) begin
      failures++;
      $display("FAIL reset_state: cmd=%0d bank=%h addr=%h pwr=%0d, required none/0/0/0",
               dut_cmd(), cmd_bank, cmd_addr, pwr_mode);
    end
    rst_n = 1'b1;

    nop(1'b1);
    drive(1, 0, 0, 3'b101, 4'h5, 14'h0123);         // ACT -> addr 17'h14123
    drive(1, 0, 1, 3'b101, 4'h2, 14'h0400);         // RDA
    drive(1, 0, 1, 3'b100, 4'h1, 14'h03FF);         // WR, addr 17'h003FF
    drive(1, 0, 1, 3'b000, 4'h3, 14'h0004);         // MRS enables MPR
    drive(1, 0, 1, 3'b101, 4'h0, 14'h0000);         // MRR
    drive(1, 0, 1, 3'b000, 4'h3, 14'h0000);         // MRS disables MPR
    drive(1, 0, 1, 3'b101, 4'h0, 14'h0000);         // RD
    drive(1, 0, 1, 3'b010, 4'h7, 14'h0400);         // PRA
    drive(1, 0, 1, 3'b011, 4'h6, 14'h0000);         // BST
    drive(1, 0, 1, 3'b110, 4'h4, 14'h0000);         // CFG
    drive(1, 1, 0, 3'b000, 4'h9, 14'h1111);         // deselect
    drive(0, 0, 1, 3'b001, 4'h0, 14'h0000);         // REF + fall -> SRF
    drive(0, 0, 0, 3'b101, 4'h5, 14'h0123);         // ACT ignored in SREF
    nop(1'b1);                                       // CKEH only
    nop(1'b0);                                       // deselect + fall -> PD
    nop(1'b1);                                       // PDX + CKEH
    drive(1, 0, 1, 3'b000, 4'h3, 14'h0004);         // MPR on
    drive(0, 0, 1, 3'b011, 4'h0, 14'h0000);         // DPD
    nop(1'b0);
    nop(1'b1);                                       // DPDX, MPR cleared
    drive(1, 0, 1, 3'b101, 4'h0, 14'h0400);         // RDA, not MRR
    drive(0, 0, 0, 3'b101, 4'h1, 14'h0001);         // illegal ACT on fall
    nop(1'b1);                                       // CKEH, still NORMAL

    // async reset while PDX is on the outputs
    nop(1'b0);
    nop(1'b1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dut_cmd() != C_NONE || CKEH || CKEL || cmd_bank != 4'h0 || cmd_addr != 17'h0 || pwr_mode != 2'd0) begin
      failures++;
      $display("FAIL async_reset: cmd=%0d ckeh=%b bank=%h addr=%h pwr=%0d, required none/0/0/0/0",
               dut_cmd(), CKEH, cmd_bank, cmd_addr, pwr_mode);
    end
    sb.delete();
    model_reset();
    cke = 1'b1; cs_n = 1'b1; act_n = 1'b1; {ras_n, cas_n, we_n} = 3'b111;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    k = 1'b1;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 9) == 0) k = ~k;
      drive(k, ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) != 0),
            3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 14'($urandom));
    end
    nop(1'b1);

    repeat (4) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memcmd_decoder.md
Name: memcmd_decoder

Overview:
- Upstream front end of the per-bank timing FSM.
- Samples raw DDR4-style command/address pins on every clk edge and decodes them.
- Produces the registered one-cycle command strobes that the FSM consumes: ACT, RD, RDA, WR, WRA, PR, PRA, REF, SRF, PD, PDX, DPD, DPDX, MRW, MRR, CFG, BST, CKEH, CKEL.
- Tracks the CKE power mode and the MPR read mode, and forwards the decoded bank and address alongside each strobe.

Parameters:
- MPR_MR, 3, mode-register index (bg_ba[1:0]) whose write updates MPR mode.
- MPR_BIT, 2, address bit of that MRS that enables MPR mode.

Ports:
- clk  in  1  command clock
- rst_n  in  1  reset
- cke  in  1  clock enable pin
- cs_n  in  1  chip select
- act_n  in  1  activate
- ras_n  in  1  RAS / A16
- cas_n  in  1  CAS / A15
- we_n  in  1  WE / A14
- bg_ba  in  4  {bank group, bank}
- addr  in  14  A13..A0
- ACT, RD, RDA, WR, WRA, PR, PRA, REF, SRF, PD, PDX, DPD, DPDX, MRW, MRR, CFG, BST, CKEH, CKEL  out  1 each  command strobes
- cmd_bank  out  4  bank of the strobed command
- cmd_addr  out  17  row (ACT) / column / MRS opcode
- pwr_mode  out  2  0 NORMAL, 1 PDN, 2 SREF, 3 DPDN

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - All strobes 0; cmd_bank 0; cmd_addr 0; pwr_mode NORMAL.
  - mpr_mode 0; cke_q 1.
- Timing:
  - All outputs are registered, with latency 1: a command sampled at edge N appears as a strobe during cycle N+1.
  - Strobes are high for exactly one cycle; at most one command strobe per cycle.
  - CKEH and CKEL may coincide with a command strobe.
- cke_q holds the previous sample of cke.
  - CKEL = cke_q & ~cke.
  - CKEH = ~cke_q & cke.
- Decode in NORMAL with cke_q=1, cke=1 and cs_n=0:
  - act_n=0 -> ACT, with cmd_addr = {ras_n, cas_n, we_n, addr}.
  - Otherwise decode {ras_n, cas_n, we_n}:
    - 000 -> MRW, cmd_addr = {3'b0, addr}. If bg_ba[1:0]==MPR_MR, mpr_mode <= addr[MPR_BIT] on the same edge.
    - 001 -> REF.
    - 010 -> PR if addr[10]=0, else PRA.
    - 011 -> BST.
    - 100 -> WR if addr[10]=0, else WRA.
    - 101 -> RD or RDA by addr[10]. When mpr_mode=1, MRR is emitted instead, regardless of addr[10].
    - 110 -> CFG (ZQ calibration).
    - 111 -> no strobe.
  - For column commands, cmd_addr = {7'b0, addr[9:0]}.
- cs_n=1 (deselect) -> no command strobe.
- cmd_bank and cmd_addr update only when a command strobe fires; otherwise they hold.
- Power-mode FSM on a CKE falling sample (cke_q=1, cke=0) in NORMAL:
  - cs_n=0 with code 001 -> SRF; go to SREF.
  - cs_n=0 with code 011 -> DPD; go to DPDN.
  - Deselect or code 111 -> PD; go to PDN.
  - Any other command with CKE falling is illegal -> no strobe; stay NORMAL.
- Exit from PDN, SREF or DPDN occurs on a CKE rising sample:
  - PDN -> PDX; return to NORMAL.
  - SREF -> no extra strobe (CKEH marks the exit); return to NORMAL.
  - DPDN -> DPDX; return to NORMAL. mpr_mode is also cleared.
- Outside NORMAL, cs_n commands are ignored and produce no strobe.
- A CKE falling edge already in low-power (glitch) -> CKEL only; no state change.
- Reset mid-operation: in-flight strobes are dropped immediately and all state returns to its reset values.

Test Plan:
- Reset, then ACT with bg_ba=4'h5, ras/cas/we=1,0,1, addr=14'h0123 -> next cycle ACT=1 for one cycle, cmd_bank=5, cmd_addr=17'h14123, all other strobes 0.
- RD with addr[10]=1, then WR with addr[10]=0, addr[9:0]=10'h3FF on consecutive cycles -> RDA, then WR on successive cycles; cmd_addr=17'h003FF on the second.
- MRS with bg_ba=4'h3 and addr[2]=1, then RD -> MRW, then MRR (not RD). MRS with addr[2]=0, then RD -> RD.
- REF with cke 1->0 -> SRF and CKEL; pwr_mode=2; an ACT during SREF gives no strobe. CKE 0->1 -> CKEH only; pwr_mode=0.
- Deselect with CKE falling -> PD, pwr_mode=1. CKE rising -> PDX + CKEH. Code 011 with CKE falling -> DPD; rise -> DPDX, and mpr_mode is cleared.
- Assert rst_n=0 asynchronously mid-cycle during PDN with a strobe pending -> all outputs 0 and pwr_mode=0 immediately, without waiting for a clk edge.
